// File: rtl/mac_tx_arbiter.sv
// rtl/mac_tx_arbiter.sv - fixed-priority TX path arbiter with UDP fairness, watchdog abort and inter-frame gap
module mac_tx_arbiter #(
    parameter int IFG_CYCLES     = 12,
    parameter int TIMEOUT_CYCLES = 4000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       arp_reply_req,
    input  logic       arp_request_req,
    input  logic       icmp_tx_req,
    input  logic       udp_tx_req,
    input  logic       mac_send_end,
    output logic       arp_reply_ack,
    output logic       arp_request_ack,
    output logic       icmp_tx_ack,
    output logic       udp_tx_ack,
    output logic [1:0] tx_sel,
    output logic       tx_busy,
    output logic       tx_timeout,
    output logic [7:0] timeout_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_BUSY  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    localparam logic [15:0] WD_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  GAP_LAST = 8'(IFG_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [2:0]  fair_q, fair_d;
    logic [15:0] wd_q, wd_d;
    logic [7:0]  gap_q, gap_d;
    logic [7:0]  tcnt_q, tcnt_d;

    logic       any_req;
    logic [1:0] winner;
    logic       wd_abort;

    assign any_req  = arp_reply_req | arp_request_req | icmp_tx_req | udp_tx_req;
    // An end pulse on the terminal count wins over the abort.
    assign wd_abort = (state_q == S_BUSY) && (wd_q == WD_LAST) && !mac_send_end;

    // UDP jumps the queue once it has been passed over four times in a row.
    always_comb begin
        winner = 2'd3;
        if (udp_tx_req && (fair_q >= 3'd4)) begin
            winner = 2'd3;
        end else if (arp_reply_req) begin
            winner = 2'd0;
        end else if (arp_request_req) begin
            winner = 2'd1;
        end else if (icmp_tx_req) begin
            winner = 2'd2;
        end else begin
            winner = 2'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sel_q   <= 2'd0;
            fair_q  <= 3'd0;
            wd_q    <= 16'd0;
            gap_q   <= 8'd0;
            tcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            fair_q  <= fair_d;
            wd_q    <= wd_d;
            gap_q   <= gap_d;
            tcnt_q  <= tcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_req) state_d = S_GRANT;
            S_GRANT: state_d = S_BUSY;
            S_BUSY:  if (mac_send_end || (wd_q == WD_LAST)) state_d = S_GAP;
            S_GAP:   if (gap_q == GAP_LAST) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sel_d  = sel_q;
        fair_d = fair_q;
        wd_d   = wd_q;
        gap_d  = gap_q;
        tcnt_d = tcnt_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    sel_d  = winner;
                    fair_d = ((winner == 2'd3) || !udp_tx_req) ? 3'd0 : 3'(fair_q + 3'd1);
                end
            end
            S_GRANT: wd_d = 16'd0;
            S_BUSY: begin
                wd_d  = 16'(wd_q + 16'd1);
                gap_d = 8'd0;
                if (wd_abort && (tcnt_q != 8'hFF)) tcnt_d = 8'(tcnt_q + 8'd1);
            end
            S_GAP:   gap_d = 8'(gap_q + 8'd1);
            default: ;
        endcase
    end

    always_comb begin
        arp_reply_ack   = (state_q == S_GRANT) && (sel_q == 2'd0);
        arp_request_ack = (state_q == S_GRANT) && (sel_q == 2'd1);
        icmp_tx_ack     = (state_q == S_GRANT) && (sel_q == 2'd2);
        udp_tx_ack      = (state_q == S_GRANT) && (sel_q == 2'd3);
        tx_busy         = (state_q == S_GRANT) || (state_q == S_BUSY);
        tx_timeout      = wd_abort;
        tx_sel          = sel_q;
        timeout_cnt     = tcnt_q;
    end

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// tb/tb_mac_tx_arbiter.sv - randomized and directed bench for mac_tx_arbiter against a behavioural model
module tb_mac_tx_arbiter;

    localparam int IFG = 12;
    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'd0;
    logic       send_end = 1'b0;
    logic       arp_reply_ack, arp_request_ack, icmp_tx_ack, udp_tx_ack;
    logic [1:0] tx_sel;
    logic       tx_busy, tx_timeout;
    logic [7:0] timeout_cnt;
    logic [3:0] ack;

    assign ack = {udp_tx_ack, icmp_tx_ack, arp_request_ack, arp_reply_ack};

    mac_tx_arbiter #(.IFG_CYCLES(IFG), .TIMEOUT_CYCLES(TMO)) dut (
        .clk             (clk),
        .rst             (rst),
        .arp_reply_req   (req[0]),
        .arp_request_req (req[1]),
        .icmp_tx_req     (req[2]),
        .udp_tx_req      (req[3]),
        .mac_send_end    (send_end),
        .arp_reply_ack   (arp_reply_ack),
        .arp_request_ack (arp_request_ack),
        .icmp_tx_ack     (icmp_tx_ack),
        .udp_tx_ack      (udp_tx_ack),
        .tx_sel          (tx_sel),
        .tx_busy         (tx_busy),
        .tx_timeout      (tx_timeout),
        .timeout_cnt     (timeout_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: a grant flag, a busy age, remaining gap cycles and a UDP starvation streak.
    bit          m_valid = 1'b0;
    bit          m_grant = 1'b0;
    bit          m_busy  = 1'b0;
    int          m_owner = 0;
    int          m_age   = 0;
    int          m_gap   = 0;
    int          m_tcnt  = 0;
    int          m_streak = 0;
    logic [15:0] exp_v, act_v;
    logic [3:0]  exp_ack;

    always @(negedge clk) begin
        if (m_valid) begin
            exp_ack = m_grant ? 4'(1 << m_owner) : 4'd0;
            exp_v = {exp_ack, 2'(m_owner), (m_grant || m_busy),
                     (m_busy && (m_age == TMO - 1) && !send_end), 8'(m_tcnt)};
            act_v = {ack, tx_sel, tx_busy, tx_timeout, timeout_cnt};
            chk("cycle_outputs", 32'(act_v), 32'(exp_v));
        end
        if (rst) begin
            m_valid = 1'b1; m_grant = 1'b0; m_busy = 1'b0; m_owner = 0;
            m_age = 0; m_gap = 0; m_tcnt = 0; m_streak = 0;
        end else if (m_grant) begin
            m_grant = 1'b0; m_busy = 1'b1; m_age = 0;
        end else if (m_busy) begin
            if (send_end) begin
                m_busy = 1'b0; m_gap = IFG;
            end else if (m_age == TMO - 1) begin
                m_busy = 1'b0; m_gap = IFG;
                if (m_tcnt < 255) m_tcnt++;
            end else begin
                m_age++;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (req != 4'd0) begin
            if (req[3] && m_streak >= 4) m_owner = 3;
            else if (req[0]) m_owner = 0;
            else if (req[1]) m_owner = 1;
            else if (req[2]) m_owner = 2;
            else m_owner = 3;
            if (m_owner == 3 || !req[3]) m_streak = 0;
            else m_streak++;
            m_grant = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(output int owner, output int lat);
        lat = 0;
        owner = -1;
        while (ack == 4'd0 && lat < 80) begin
            tick();
            lat++;
        end
        if (ack == 4'd0) chk("ack_wait_bound", 32'(ack), 32'd1);
        for (int i = 0; i < 4; i++) if (ack[i]) owner = i;
    endtask

    // Wait for a grant, hold the path for 'frame' BUSY cycles, end it; returns in the first gap cycle.
    task automatic serve(input int frame, input bit keep, output int owner, output int lat);
        wait_ack(owner, lat);
        if (owner >= 0) begin
            if (!keep) req[owner] = 1'b0;
            tick();
            repeat (frame - 1) tick();
            send_end = 1'b1;
            tick();
            send_end = 1'b0;
        end
    endtask

    initial begin
        int o, lat, n;

        rst = 1'b1;
        repeat (3) tick();
        chk("reset_busy", 32'(tx_busy), 32'd0);
        chk("reset_sel", 32'(tx_sel), 32'd0);
        chk("reset_tcnt", 32'(timeout_cnt), 32'd0);
        chk("reset_ack", 32'(ack), 32'd0);
        rst = 1'b0;
        tick();

        // Single UDP frame, then regrant latency across the gap
        req[3] = 1'b1;
        tick();
        chk("udp_ack", 32'(udp_tx_ack), 32'd1);
        chk("udp_sel", 32'(tx_sel), 32'd3);
        chk("udp_busy", 32'(tx_busy), 32'd1);
        req[3] = 1'b0;
        repeat (10) tick();
        send_end = 1'b1;
        #1;
        chk("busy_in_end_cycle", 32'(tx_busy), 32'd1);
        tick();
        send_end = 1'b0;
        chk("busy_after_end", 32'(tx_busy), 32'd0);
        req[3] = 1'b1;
        serve(3, 1'b0, o, lat);
        chk("udp_regrant_lat", 32'(lat), 32'd13);
        chk("udp_regrant_owner", 32'(o), 32'd3);

        // All four together: strict priority order
        req = 4'hF;
        for (int i = 0; i < 4; i++) begin
            serve(4, 1'b0, o, lat);
            chk("all4_owner", 32'(o), 32'(i));
            chk("all4_spacing", 32'(lat), 32'd13);
        end

        // ICMP and UDP held: four ICMP then one UDP, repeating
        req[2] = 1'b1;
        req[3] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            serve(2, 1'b1, o, lat);
            chk("fair_owner", 32'(o), (i % 5 == 4) ? 32'd3 : 32'd2);
        end
        req = 4'd0;

        // Watchdog abort
        req[0] = 1'b1;
        wait_ack(o, lat);
        req[0] = 1'b0;
        n = 0;
        tick();
        n++;
        while (!tx_timeout && n < 40) begin
            tick();
            n++;
        end
        chk("timeout_delay", 32'(n), 32'd16);
        chk("tcnt_before_abort", 32'(timeout_cnt), 32'd0);
        tick();
        chk("tcnt_after_abort", 32'(timeout_cnt), 32'd1);
        chk("busy_after_abort", 32'(tx_busy), 32'd0);
        req[0] = 1'b1;
        wait_ack(o, lat);
        chk("abort_gap_lat", 32'(lat), 32'd13);

        // End pulse coincident with terminal watchdog count
        req[0] = 1'b0;
        repeat (16) tick();
        send_end = 1'b1;
        #1;
        chk("coincident_no_timeout", 32'(tx_timeout), 32'd0);
        chk("coincident_busy", 32'(tx_busy), 32'd1);
        tick();
        send_end = 1'b0;
        chk("coincident_tcnt", 32'(timeout_cnt), 32'd1);
        chk("coincident_done", 32'(tx_busy), 32'd0);

        // Reset mid-frame with another request held
        req[1] = 1'b1;
        req[2] = 1'b1;
        wait_ack(o, lat);
        chk("pre_reset_owner", 32'(o), 32'd1);
        req[1] = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        chk("midreset_out", 32'({ack, tx_sel, tx_busy, tx_timeout, timeout_cnt}), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_reset_ack", 32'(icmp_tx_ack), 32'd1);
        chk("post_reset_sel", 32'(tx_sel), 32'd2);
        req[2] = 1'b0;
        repeat (3) tick();
        send_end = 1'b1;
        tick();
        send_end = 1'b0;

        // Randomized traffic checked cycle by cycle against the model
        repeat (5000) begin
            for (int i = 0; i < 4; i++) begin
                if (req[i] && ack[i]) req[i] = 1'b0;
                else if (!req[i] && ($urandom % 8 == 0)) req[i] = 1'b1;
                else if (req[i] && ($urandom % 64 == 0)) req[i] = 1'b0;
            end
            send_end = tx_busy ? ($urandom % 12 == 0) : ($urandom % 40 == 0);
            rst = ($urandom % 700 == 0);
            tick();
        end
        rst = 1'b0;
        req = 4'd0;
        send_end = 1'b0;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mac_tx_arbiter.md
MAC_TX_ARBITER -- requirements
Module: mac_tx_arbiter

Interface
REQ-001 Parameter IFG_CYCLES, default 12, idle cycles enforced between the end of one frame and the next grant (range 1..255).
REQ-002 Parameter TIMEOUT_CYCLES, default 4000, maximum BUSY cycles without mac_send_end before abort (range 16..65535).
REQ-003 clk  input  1  transmit clock (gmii_tx_clk domain); all logic is on its rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 arp_reply_req  input  1  ARP reply requester; level, held until granted.
REQ-006 arp_request_req  input  1  ARP request requester; level, held until granted.
REQ-007 icmp_tx_req  input  1  ICMP echo-reply requester; level, held until granted.
REQ-008 udp_tx_req  input  1  UDP requester; level, held until granted.
REQ-009 mac_send_end  input  1  one-cycle pulse from the MAC TX path marking the last byte of the frame.
REQ-010 arp_reply_ack / arp_request_ack / icmp_tx_ack / udp_tx_ack  output  1 each  one-cycle grant pulses.
REQ-011 tx_sel  output  2  owner of the TX path: 0 ARP reply, 1 ARP request, 2 ICMP, 3 UDP; valid while tx_busy=1.
REQ-012 tx_busy  output  1  high from the grant cycle through the cycle of mac_send_end or abort.
REQ-013 tx_timeout  output  1  one-cycle pulse on watchdog abort.
REQ-014 timeout_cnt  output  8  saturating count of watchdog aborts since reset.

Function
REQ-015 States: IDLE, GRANT, BUSY, GAP; encoding is free, but the state is observable only through the outputs.
REQ-016 IDLE: when any request is high, move to GRANT next cycle, latching the winner into tx_sel; stay in IDLE when none is high.
REQ-017 Priority: ARP reply > ARP request > ICMP > UDP, with one fairness exception.
REQ-018 Fairness: after 4 consecutive grants to ARP/ICMP while udp_tx_req was high at each of those grant decisions, the next decision with udp_tx_req high goes to UDP.
REQ-019 Fairness counter reset: any UDP grant, and any decision made with udp_tx_req low, clears the 3-bit counter.
REQ-020 GRANT: lasts exactly one cycle; the ack matching tx_sel pulses high for that cycle only; tx_busy rises in the same cycle; next state is BUSY.
REQ-021 Request latency: from a request sampled high in IDLE to its ack is 1 cycle.
REQ-022 BUSY: tx_sel and tx_busy hold steady; requests are ignored, and a requester keeps its request high until acked.
REQ-023 BUSY end: mac_send_end=1 moves the state to GAP; tx_busy drops the cycle after the pulse.
REQ-024 Watchdog: a 16-bit counter clears on GRANT and increments each BUSY cycle.
REQ-025 Watchdog abort: when the counter reaches TIMEOUT_CYCLES-1 with no mac_send_end, pulse tx_timeout for one cycle, increment timeout_cnt (saturating at 255), and enter GAP.
REQ-026 Simultaneous events: mac_send_end in the same cycle as the timeout terminal count counts as normal completion; no tx_timeout pulse.
REQ-027 GAP: an 8-bit counter runs for IFG_CYCLES cycles, then the state returns to IDLE; no ack may pulse during GAP.
REQ-028 Minimum spacing: between successive ack pulses = 1 (GRANT) + frame cycles + IFG_CYCLES + 1 (IDLE decision).
REQ-029 Stray end pulse: mac_send_end outside BUSY is ignored.
REQ-030 Dropped request: a requester dropping its request before the decision is not granted; the decision uses only the request levels in the IDLE cycle.
REQ-031 Exclusivity: at most one ack output is high in any cycle; tx_sel never changes while tx_busy=1.

Reset
REQ-032 With rst=1 at a clock edge: state IDLE; all acks 0; tx_busy 0; tx_sel 0; tx_timeout 0; timeout_cnt 0; fairness, watchdog and gap counters 0.
REQ-033 Reset asserted mid-frame (BUSY or GAP) aborts immediately without a tx_timeout pulse; the first grant after release follows REQ-016.

Verification
REQ-034 Single UDP: udp_tx_req=1 in IDLE -> udp_tx_ack at cycle+1, tx_sel=3; mac_send_end 100 cycles later -> next grant no earlier than 12 cycles after tx_busy falls.
REQ-035 All four requests high together -> grants in order 0,1,2,3 (ARP reply, ARP request, ICMP, UDP), each separated by frame + 12-cycle gap.
REQ-036 Fairness: udp_tx_req and icmp_tx_req held high continuously -> ICMP granted 4 times, then UDP once; pattern repeats.
REQ-037 Watchdog with TIMEOUT_CYCLES=16: grant, no mac_send_end -> tx_timeout pulses 16 cycles after GRANT, timeout_cnt=1, return to IDLE after 12 GAP cycles.
REQ-038 mac_send_end coincident with the terminal watchdog count -> no tx_timeout, timeout_cnt unchanged.
REQ-039 rst pulsed during BUSY -> next cycle all outputs at reset values; held request is granted 1 cycle after rst deasserts.
